sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, SHALL set the cycles each 16-bit SRAM half-access occupies; legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 1024, SHALL be the byte address of data-memory word 0.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 MEM_R_EN  in  1  SHALL be the MEM-stage read request.
REQ-006 MEM_W_EN  in  1  SHALL be the MEM-stage write request.
REQ-007 Address  in  32  SHALL be the ALU-computed byte address, word aligned.
REQ-008 Write_Data  in  32  SHALL be the store data.
REQ-009 Read_Data  out  32  SHALL be the registered load result.
REQ-010 Ready  out  1  SHALL be high when the MEM stage may advance; pipeline Freeze is ~Ready.
REQ-011 SRAM_ADDR  out  18  SHALL be the external half-word address.
REQ-012 SRAM_DQ_in  in  16  SHALL be the read data from the SRAM pins.
REQ-013 SRAM_DQ_out  out  16  SHALL be the write data driven to the SRAM pins.
REQ-014 SRAM_DQ_OE  out  1  SHALL be high only while SRAM_DQ_out is to be driven.
REQ-015 SRAM_WE_N  out  1  SHALL be the active-low SRAM write strobe.

Function
REQ-016 FSM states IDLE, LOW, HIGH, DONE; a 4-bit cycle counter SHALL count ACCESS_CYCLES within LOW and HIGH.
REQ-017 req = MEM_R_EN | MEM_W_EN; with both asserted the access SHALL be a write and Read_Data SHALL be unchanged.
REQ-018 IDLE: req=1 -> LOW with the counter cleared; req=0 -> stay in IDLE.
REQ-019 LOW/HIGH: SHALL stay for exactly ACCESS_CYCLES cycles each; LOW -> HIGH -> DONE; DONE -> IDLE unconditionally.
REQ-020 Ready SHALL be combinational: 1 in IDLE with req=0, 1 in DONE, 0 otherwise.
REQ-021 With ACCESS_CYCLES=2, Ready SHALL be low for exactly 5 consecutive cycles (request cycle + 2 LOW + 2 HIGH) and high in the DONE cycle.
REQ-022 A req still asserted in DONE SHALL NOT start a new access; the next access starts only from IDLE.
REQ-023 Word index = (Address - BASE_ADDR) mod 2^32, bits [18:2]; SRAM_ADDR = {index, 0} in LOW and {index, 1} in HIGH; other bits are ignored.
REQ-024 Read: SRAM_DQ_in SHALL be captured into the low half in the last LOW cycle and into the high half in the last HIGH cycle; Read_Data SHALL take the assembled word at entry to DONE and hold it until the next read completes.
REQ-025 Write: SRAM_DQ_out = Write_Data[15:0] in LOW and [31:16] in HIGH; SRAM_DQ_OE=1 and SRAM_WE_N=0 for every LOW/HIGH cycle of a write.
REQ-026 Outside write LOW/HIGH cycles: SRAM_WE_N=1 and SRAM_DQ_OE=0; SRAM_ADDR=0 and SRAM_DQ_out=0 in IDLE and DONE.
REQ-027 Address and Write_Data SHALL be used live; the pipeline holds them stable while Ready=0.

Reset
REQ-028 rst low SHALL force IDLE, counter=0, Read_Data=0, SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0 and SRAM_DQ_out=0 immediately, including mid-access.
REQ-029 After rst is released, a held req SHALL start a fresh access from IDLE; an access interrupted by reset SHALL NOT be resumed.

Structure
REQ-030 State encoding, BASE_ADDR default and ACCESS_CYCLES default SHALL live in the shared processor package.
REQ-031 The block SHALL be a single module with no sub-modules; the FSM and counter are inline.

Verification
REQ-032 Write 0xDEADBEEF to Address 1024 (ACCESS_CYCLES=2) -> SRAM_ADDR 0 with DQ 0xBEEF, then 1 with 0xDEAD, WE_N low 4 cycles, Ready low 5 cycles.
REQ-033 Read Address 1028 with SRAM model returning 0x5678 then 0x1234 -> SRAM_ADDR 2, 3; Read_Data=0x12345678 in the DONE cycle.
REQ-034 Both MEM_R_EN and MEM_W_EN high -> write performed, Read_Data unchanged.
REQ-035 Req held through DONE -> exactly one access; Ready high one cycle, then back-to-back second access begins from IDLE.
REQ-036 rst asserted in the 2nd HIGH cycle -> outputs reset asynchronously, WE_N=1 at once; after release a held read completes normally.
REQ-037 ACCESS_CYCLES=1 -> Ready low 3 cycles per access.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// default timing/base address, and the byte-address to SRAM word-index mapping.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int unsigned ACCESS_CYCLES_DEFAULT = 2;
  localparam logic [31:0] BASE_ADDR_DEFAULT     = 32'd1024;

  // Offset wraps modulo 2^32, so addresses below the base alias to the top of SRAM.
  function automatic logic [16:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return offset[18:2];
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side MEM-stage bus between the CPU and the SRAM controller.
interface sram_controller_if;

  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data;
  logic        Ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, Address, Write_Data,
    input  Read_Data, Ready
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, Address, Write_Data,
    output Read_Data, Ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM half-accesses
// (low half, then high half), stalling the pipeline via Ready until done.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT,
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    bus,
  output logic [17:0]         SRAM_ADDR,
  input  logic [15:0]         SRAM_DQ_in,
  output logic [15:0]         SRAM_DQ_out,
  output logic                SRAM_DQ_OE,
  output logic                SRAM_WE_N
);

  localparam logic [3:0] LAST_CYCLE = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] low_half;
  logic [31:0] read_data;
  logic        ready;
  logic        req;
  logic        is_write;
  logic        last_cycle;
  logic [16:0] idx;

  // A write wins when both enables are high, so only pure reads touch Read_Data.
  assign req        = bus.MEM_R_EN | bus.MEM_W_EN;
  assign is_write   = bus.MEM_W_EN;
  assign idx        = word_index(bus.Address, BASE_ADDR);
  assign last_cycle = (cnt == LAST_CYCLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready       = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_OE  = 1'b0;
    SRAM_WE_N   = 1'b1;
    unique case (state)
      IDLE: begin
        ready = !req;
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        SRAM_ADDR   = {idx, 1'b0};
        SRAM_DQ_out = bus.Write_Data[15:0];
        SRAM_DQ_OE  = is_write;
        SRAM_WE_N   = !is_write;
        if (last_cycle) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH: begin
        SRAM_ADDR   = {idx, 1'b1};
        SRAM_DQ_out = bus.Write_Data[31:16];
        SRAM_DQ_OE  = is_write;
        SRAM_WE_N   = !is_write;
        if (last_cycle) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the read-data registers are datapath, yet they are reset because
  // Read_Data is architecturally visible and must read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_half  <= '0;
      read_data <= '0;
    end else if (!is_write && last_cycle) begin
      if (state == LOW)  low_half  <= SRAM_DQ_in;
      if (state == HIGH) read_data <= {SRAM_DQ_in, low_half};
    end
  end

  assign bus.Ready     = ready;
  assign bus.Read_Data = read_data;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: random MEM-stage accesses against a word-level memory
// model, plus directed write/read/both/back-to-back/reset/ACCESS_CYCLES=1 cases.
module tb_sram_controller;

  localparam int unsigned K    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus0 ();
  sram_controller_if bus1 ();

  logic [17:0] sram_addr0, sram_addr1;
  logic [15:0] dq_in0, dq_out0, dq_in1, dq_out1;
  logic        oe0, oe1, we_n0, we_n1;

  sram_controller #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .SRAM_ADDR(sram_addr0), .SRAM_DQ_in(dq_in0), .SRAM_DQ_out(dq_out0),
    .SRAM_DQ_OE(oe0), .SRAM_WE_N(we_n0)
  );

  sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .SRAM_ADDR(sram_addr1), .SRAM_DQ_in(dq_in1), .SRAM_DQ_out(dq_out1),
    .SRAM_DQ_OE(oe1), .SRAM_WE_N(we_n1)
  );

  // Half-word SRAM model: unwritten locations return a fixed pattern.
  logic [15:0] sram    [0:262143];
  bit          written [0:262143];

  function automatic logic [15:0] pat(input int unsigned a);
    if (a == 2) return 16'h5678;
    if (a == 3) return 16'h1234;
    return 16'((a * 40503) ^ 32'h5a3c);
  endfunction

  always @(posedge clk) begin
    if (!we_n0 && oe0) begin
      sram[sram_addr0]    <= dq_out0;
      written[sram_addr0] <= 1'b1;
    end
  end

  assign dq_in0 = written[sram_addr0] ? sram[sram_addr0] : pat(32'(sram_addr0));
  assign dq_in1 = 16'hA5C3;

  // Word-level reference: what a 32-bit load at a word index must return.
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;

  function automatic logic [16:0] model_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return 17'((off >> 2) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] model_read(input logic [16:0] idx);
    int unsigned i;
    i = 32'(idx);
    if (ref_mem.exists(i)) return ref_mem[i];
    return {pat(2 * i + 1), pat(2 * i)};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called right at a negedge; returns at the negedge sample of the DONE cycle.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic [16:0] idx;
    logic [31:0] exp_rd;
    int          n_low;
    bit          done;
    idx             = model_index(addr);
    bus0.MEM_R_EN   = rd;
    bus0.MEM_W_EN   = wr;
    bus0.Address    = addr;
    bus0.Write_Data = wdata;
    n_low = 0;
    done  = 0;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (bus0.Ready) begin
        done = 1;
      end else begin
        if (c == 0) begin
          check("req_cycle_addr", 32'(sram_addr0), 32'd0);
          check("req_cycle_we_n", 32'(we_n0), 32'd1);
          check("req_cycle_oe", 32'(oe0), 32'd0);
        end else if (c <= 2 * K) begin
          check("access_addr", 32'(sram_addr0),
                32'({idx, (c > K) ? 1'b1 : 1'b0}));
          check("access_we_n", 32'(we_n0), 32'(!wr));
          check("access_oe", 32'(oe0), 32'(wr));
          if (wr)
            check("access_dq_out", 32'(dq_out0),
                  (c > K) ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
        end
        n_low++;
      end
    end
    check("done_seen", 32'(done), 32'd1);
    check("ready_low_cycles", 32'(n_low), 32'(2 * K + 1));
    check("done_addr", 32'(sram_addr0), 32'd0);
    check("done_dq_out", 32'(dq_out0), 32'd0);
    check("done_we_n", 32'(we_n0), 32'd1);
    check("done_oe", 32'(oe0), 32'd0);
    if (rd && !wr) begin
      exp_rd  = model_read(idx);
      last_rd = exp_rd;
    end
    check("read_data", bus0.Read_Data, last_rd);
    if (wr) ref_mem[32'(idx)] = wdata;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus0.MEM_R_EN = 1'b0;
    bus0.MEM_W_EN = 1'b0;
    #1;
    check("idle_ready", 32'(bus0.Ready), 32'd1);
    check("idle_we_n", 32'(we_n0), 32'd1);
    check("idle_addr", 32'(sram_addr0), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          sel;
    rst = 1'b0;
    last_rd = '0;
    bus0.MEM_R_EN = 0; bus0.MEM_W_EN = 0; bus0.Address = '0; bus0.Write_Data = '0;
    bus1.MEM_R_EN = 0; bus1.MEM_W_EN = 0; bus1.Address = '0; bus1.Write_Data = '0;
    repeat (3) @(negedge clk);
    check("rst_read_data", bus0.Read_Data, 32'd0);
    check("rst_we_n", 32'(we_n0), 32'd1);
    check("rst_oe", 32'(oe0), 32'd0);
    check("rst_addr", 32'(sram_addr0), 32'd0);
    check("rst_dq_out", 32'(dq_out0), 32'd0);
    check("rst_ready", 32'(bus0.Ready), 32'd1);
    rst = 1'b1;

    // Directed write, read, write-wins, back-to-back and wrap-around accesses.
    @(negedge clk); do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    go_idle();
    @(negedge clk); do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    check("read_1028", bus0.Read_Data, 32'h12345678);
    go_idle();
    @(negedge clk); do_access(1'b1, 1'b1, BASE + 32'd8, 32'hCAFEF00D);
    go_idle();
    @(negedge clk); do_access(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    @(negedge clk); do_access(1'b1, 1'b0, BASE + 32'd28, 32'h0);
    @(negedge clk); do_access(1'b1, 1'b0, BASE + 32'd28, 32'h0);
    go_idle();
    @(negedge clk); do_access(1'b0, 1'b1, BASE - 32'd4, 32'h0BADC0DE);
    go_idle();
    @(negedge clk); do_access(1'b1, 1'b0, BASE - 32'd4, 32'h0);
    go_idle();

    // Reset in the second HIGH cycle of a write, then a held read after release.
    @(negedge clk);
    bus0.MEM_R_EN = 1'b0; bus0.MEM_W_EN = 1'b1;
    bus0.Address = BASE + 32'd20; bus0.Write_Data = 32'h13579BDF;
    repeat (4) @(negedge clk);
    check("high2_we_n", 32'(we_n0), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_we_n", 32'(we_n0), 32'd1);
    check("mid_rst_oe", 32'(oe0), 32'd0);
    check("mid_rst_addr", 32'(sram_addr0), 32'd0);
    check("mid_rst_dq_out", 32'(dq_out0), 32'd0);
    check("mid_rst_read_data", bus0.Read_Data, 32'd0);
    ref_mem[5] = 32'h13579BDF;
    last_rd    = '0;
    bus0.MEM_W_EN = 1'b0; bus0.MEM_R_EN = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_access(1'b1, 1'b0, BASE + 32'd20, 32'h0);
    go_idle();

    // Random traffic over a small word window, with ignored upper address bits.
    for (int t = 0; t < 40; t++) begin
      a   = BASE + 32'($urandom_range(0, 15)) * 4 + (32'($urandom_range(0, 3)) << 19);
      d   = $urandom;
      sel = $urandom_range(0, 2);
      @(negedge clk);
      do_access(sel != 1, sel != 0, a, d);
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    // ACCESS_CYCLES=1 instance: three Ready-low cycles per access.
    begin
      logic [31:0] last_rd1;
      int          n, w;
      bit          rd1;
      last_rd1 = '0;
      for (int t = 0; t < 4; t++) begin
        rd1 = (t % 2 == 0);
        @(negedge clk);
        bus1.MEM_R_EN   = rd1;
        bus1.MEM_W_EN   = !rd1;
        bus1.Address    = BASE + 32'(t) * 4;
        bus1.Write_Data = $urandom;
        n = 0; w = 0;
        #1;
        while (!bus1.Ready && n < 20) begin
          n++;
          if (!we_n1) w++;
          @(negedge clk);
        end
        check("ac1_ready_low", 32'(n), 32'd3);
        check("ac1_we_cycles", 32'(w), rd1 ? 32'd0 : 32'd2);
        if (rd1) last_rd1 = 32'hA5C3A5C3;
        check("ac1_read_data", bus1.Read_Data, last_rd1);
        @(negedge clk);
        bus1.MEM_R_EN = 1'b0;
        bus1.MEM_W_EN = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
